// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and the queue entry type for the fetch stage.
package fetch_pkg;
    localparam int              XLEN             = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0040_0000;
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;

    // One buffered fetch: the instruction word and the PC it was fetched from.
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: small synchronous FIFO of fetch entries with push/pop/flush.
// Flush wins over push and pop in the same cycle. Head is valid whenever
// count is non-zero; storage itself is not reset.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output logic [CW-1:0] count,
    output fetch_entry_t head,
    output logic         valid
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign valid   = (count != '0);
    assign do_pop  = pop && valid;
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    // entry storage; written only on an accepted, non-flushed push
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

    // pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the PC, issues in-order imem
// requests under a credit limit (queued + in flight <= FIFO_DEPTH), queues the
// returned words and presents the head to the fetch/decode register.
// A redirect flushes the queue and marks every outstanding fetch for discard.
// Optional macro FETCH_PERF_EN adds saturating stall/redirect/discard counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imemReq,
    output logic [XLEN-1:0] imemAddr,
    input  logic            imemGnt,
    input  logic            imemRvalid,
    input  logic [XLEN-1:0] imemRdata,
    input  logic            fdWe,
    input  logic            redirectIN,
    input  logic [XLEN-1:0] redirectPC,
    output logic            validOUT,
    output logic [XLEN-1:0] instructionOUT,
    output logic [XLEN-1:0] pcOUT,
    output logic [XLEN-1:0] pcPlus4OUT
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perfStallCycles,
    output logic [31:0]     perfRedirects,
    output logic [31:0]     perfDiscards
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] resp_pc;   // PC of the next response that will be kept
    logic [XLEN-1:0] target;
    logic [CW-1:0]   count;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   inflight_next;
    logic [CW-1:0]   discard;
    logic [CW:0]     used;
    logic            grant;
    logic            drop;
    logic            push;
    logic            pop;
    logic            q_valid;
    fetch_entry_t    head;
    fetch_entry_t    push_entry;

    // misaligned targets are silently aligned
    assign target        = {redirectPC[XLEN-1:2], 2'b00};
    assign used          = {1'b0, count} + {1'b0, inflight};
    assign imemReq       = !reset && !redirectIN && (used < (CW + 1)'(FIFO_DEPTH));
    assign imemAddr      = pc;
    assign grant         = imemReq && imemGnt;
    assign drop          = imemRvalid && (redirectIN || (discard != '0));
    assign push          = imemRvalid && !drop;
    assign pop           = q_valid && fdWe;
    assign inflight_next = inflight + CW'(grant) - CW'(imemRvalid);
    assign push_entry    = '{instr: imemRdata, pc: resp_pc};

    // kept responses are exactly the current path in order, so their PC is a
    // running counter restarted at each redirect target
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc       <= RESET_PC;
            resp_pc  <= RESET_PC;
            inflight <= '0;
            discard  <= '0;
        end else begin
            inflight <= inflight_next;
            if (redirectIN) begin
                pc      <= target;
                resp_pc <= target;
                discard <= inflight_next;
            end else begin
                if (grant) pc <= pc + 32'd4;
                if (push)  resp_pc <= resp_pc + 32'd4;
                if (imemRvalid && (discard != '0)) discard <= discard - CW'(1);
            end
        end
    end

    fetch_queue #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirectIN),
        .count     (count),
        .head      (head),
        .valid     (q_valid)
    );

    assign validOUT       = q_valid;
    assign instructionOUT = q_valid ? head.instr : NOP_INSTR;
    assign pcOUT          = q_valid ? head.pc : '0;
    assign pcPlus4OUT     = q_valid ? head.pc + 32'd4 : '0;

    // a response with nothing outstanding means memory and fetch disagree
    property p_no_orphan_resp;
        @(posedge clk) disable iff (reset) imemRvalid |-> (inflight != '0);
    endproperty
    assert property (p_no_orphan_resp);

`ifdef FETCH_PERF_EN
    // saturating event counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perfStallCycles <= '0;
            perfRedirects   <= '0;
            perfDiscards    <= '0;
        end else begin
            if (q_valid && !fdWe && (perfStallCycles != '1)) perfStallCycles <= perfStallCycles + 32'd1;
            if (redirectIN && (perfRedirects != '1))         perfRedirects   <= perfRedirects + 32'd1;
            if (drop && (perfDiscards != '1))                perfDiscards    <= perfDiscards + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with an in-order memory model
// of configurable latency and a PC scoreboard on every decode pop.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemGnt;
    logic        imemRvalid;
    logic [31:0] imemRdata;
    logic        fdWe;
    logic        redirectIN;
    logic [31:0] redirectPC;
    logic        validOUT;
    logic [31:0] instructionOUT;
    logic [31:0] pcOUT;
    logic [31:0] pcPlus4OUT;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_stall, perf_redir, perf_disc;
`endif

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .reset(reset), .imemReq(imemReq), .imemAddr(imemAddr),
        .imemGnt(imemGnt), .imemRvalid(imemRvalid), .imemRdata(imemRdata),
        .fdWe(fdWe), .redirectIN(redirectIN), .redirectPC(redirectPC),
        .validOUT(validOUT), .instructionOUT(instructionOUT), .pcOUT(pcOUT),
        .pcPlus4OUT(pcPlus4OUT)
`ifdef FETCH_PERF_EN
        , .perfStallCycles(perf_stall), .perfRedirects(perf_redir), .perfDiscards(perf_disc)
`endif
    );

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { logic req; logic [31:0] addr; logic vld; logic [31:0] pc; } vec_t;

    mreq_t       mq[$];
    vec_t        t1[8];
    int          lat, cyc, checks, errors;
    logic        n_fdwe, n_redir;
    logic [31:0] n_rpc, exp_pc, exp_req;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // one cycle: drive at negedge, sample 1 unit later, update memory model and scoreboard
    task automatic step();
        @(negedge clk);
        fdWe       = n_fdwe;
        redirectIN = n_redir;
        redirectPC = n_rpc;
        imemRvalid = 1'b0;
        imemRdata  = '0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imemRvalid = 1'b1;
            imemRdata  = word_of(mq[0].addr);
            void'(mq.pop_front());
        end
        #1;
        if (validOUT) begin
            chk("pcplus4", pcPlus4OUT, pcOUT + 32'd4);
            chk("instr_of_pc", instructionOUT, word_of(pcOUT));
        end else begin
            chk("idle_instr", instructionOUT, NOP_INSTR);
            chk("idle_pc", pcOUT, 32'h0);
            chk("idle_pc4", pcPlus4OUT, 32'h0);
        end
        if (validOUT && fdWe) begin
            chk("pop_pc", pcOUT, exp_pc);
            exp_pc = exp_pc + 32'd4;
        end
        if (imemReq) chk("req_addr", imemAddr, exp_req);
        if (imemReq && imemGnt) begin
            mq.push_back('{addr: imemAddr, due: cyc + lat});
            exp_req = exp_req + 32'd4;
        end
        if (redirectIN) begin
            chk("req_on_redirect", {31'b0, imemReq}, 32'h0);
            exp_pc  = {redirectPC[31:2], 2'b00};
            exp_req = {redirectPC[31:2], 2'b00};
        end
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mq.delete();
        imemRvalid = 1'b0;
        n_redir = 1'b0;
        redirectIN = 1'b0;
        fdWe = n_fdwe;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        cyc = 0;
        exp_pc  = RESET_PC_DEFAULT;
        exp_req = RESET_PC_DEFAULT;
    endtask

    task automatic wait_valid(input string nm, input int budget);
        int n = 0;
        do begin step(); n++; end while (!validOUT && n < budget);
        if (!validOUT) begin
            checks++; errors++;
            $display("FAIL %s: got no validOUT expected one within %0d cycles", nm, budget);
        end
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; lat = 1;
        reset = 1'b1; imemGnt = 1'b1; imemRvalid = 1'b0; imemRdata = '0;
        fdWe = 1'b1; redirectIN = 1'b0; redirectPC = '0;
        n_fdwe = 1'b1; n_redir = 1'b0; n_rpc = '0;
        exp_pc = RESET_PC_DEFAULT; exp_req = RESET_PC_DEFAULT;

        // latency 1, gnt always, decode never stalls: period-3 pattern, 2 pops per 3 cycles
        t1[0] = '{1'b1, 32'h0040_0000, 1'b0, 32'h0};
        t1[1] = '{1'b1, 32'h0040_0004, 1'b0, 32'h0};
        t1[2] = '{1'b0, 32'h0,         1'b1, 32'h0040_0000};
        t1[3] = '{1'b1, 32'h0040_0008, 1'b1, 32'h0040_0004};
        t1[4] = '{1'b1, 32'h0040_000C, 1'b0, 32'h0};
        t1[5] = '{1'b0, 32'h0,         1'b1, 32'h0040_0008};
        t1[6] = '{1'b1, 32'h0040_0010, 1'b1, 32'h0040_000C};
        t1[7] = '{1'b1, 32'h0040_0014, 1'b0, 32'h0};

        // reset state
        #3;
        chk("rst_req", {31'b0, imemReq}, 32'h0);
        chk("rst_valid", {31'b0, validOUT}, 32'h0);
        chk("rst_instr", instructionOUT, NOP_INSTR);
        chk("rst_pc", pcOUT, 32'h0);
        chk("rst_pc4", pcPlus4OUT, 32'h0);

        // 1: streaming from RESET_PC
        lat = 1; n_fdwe = 1'b1; do_reset();
        for (int i = 0; i < 8; i++) begin
            step();
            chk("t1_req", {31'b0, imemReq}, {31'b0, t1[i].req});
            if (t1[i].req) chk("t1_addr", imemAddr, t1[i].addr);
            chk("t1_valid", {31'b0, validOUT}, {31'b0, t1[i].vld});
            chk("t1_pc", pcOUT, t1[i].pc);
        end

        // 2: decode stall with full queue, then resume
        lat = 1; n_fdwe = 1'b0; do_reset();
        repeat (3) step();
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t2_req_stalled", {31'b0, imemReq}, 32'h0);
            chk("t2_valid", {31'b0, validOUT}, 32'h1);
            chk("t2_pc_frozen", pcOUT, 32'h0040_0000);
            chk("t2_instr_frozen", instructionOUT, word_of(32'h0040_0000));
        end
        n_fdwe = 1'b1;
        repeat (12) step();
        chk("t2_resume_pops", exp_pc, 32'h0040_0020);

        // 3: latency 3, two in flight, redirect drops both
        lat = 3; n_fdwe = 1'b1; do_reset();
        repeat (2) step();
        n_redir = 1'b1; n_rpc = 32'h0000_1000;
        step();
        n_redir = 1'b0;
        wait_valid("t3_wait", 20);
        chk("t3_first_pc", pcOUT, 32'h0000_1000);

        // 4: redirect coinciding with a response; misaligned target
        lat = 2; do_reset();
        repeat (2) step();
        n_redir = 1'b1; n_rpc = 32'h0000_2002;
        step();
        n_redir = 1'b0;
        step();
        chk("t4_next_req", {31'b0, imemReq}, 32'h1);
        chk("t4_next_addr", imemAddr, 32'h0000_2000);
        wait_valid("t4_wait", 20);
        chk("t4_first_pc", pcOUT, 32'h0000_2000);

        // 5a: async reset with two fetches in flight, then restart
        lat = 3; do_reset();
        repeat (3) step();
        #2 reset = 1'b1;
        #1;
        chk("t5_req", {31'b0, imemReq}, 32'h0);
        chk("t5_valid", {31'b0, validOUT}, 32'h0);
        do_reset();
        step();
        chk("t5_restart_addr", imemAddr, RESET_PC_DEFAULT);
        wait_valid("t5_wait", 20);
        chk("t5_restart_pc", pcOUT, RESET_PC_DEFAULT);
        // 5b: async reset while an instruction is presented
        lat = 1; n_fdwe = 1'b0; do_reset();
        repeat (3) step();
        chk("t5b_pre_valid", {31'b0, validOUT}, 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("t5b_valid", {31'b0, validOUT}, 32'h0);
        chk("t5b_instr", instructionOUT, NOP_INSTR);
        chk("t5b_pc", pcOUT, 32'h0);
        n_fdwe = 1'b1;

        // 6: PC wrap at top of address space
        lat = 1; do_reset();
        n_redir = 1'b1; n_rpc = 32'hFFFF_FFFC;
        step();
        n_redir = 1'b0;
        step();
        chk("t6_addr_top", imemAddr, 32'hFFFF_FFFC);
        step();
        chk("t6_addr_wrap", imemAddr, 32'h0000_0000);
        wait_valid("t6_wait", 20);
        chk("t6_pc", pcOUT, 32'hFFFF_FFFC);
        chk("t6_pc4", pcPlus4OUT, 32'h0000_0000);
        repeat (6) step();

        // 7: back-to-back redirects, last target wins
        lat = 3; do_reset();
        repeat (2) step();
        n_redir = 1'b1; n_rpc = 32'h0000_3000;
        step();
        n_rpc = 32'h0000_5000;
        step();
        n_redir = 1'b0;
        wait_valid("t7_wait", 20);
        chk("t7_first_pc", pcOUT, 32'h0000_5000);

        // 8: redirect in the same cycle decode pops the head
        lat = 1; do_reset();
        repeat (2) step();
        n_redir = 1'b1; n_rpc = 32'h0000_8000;
        step();
        n_redir = 1'b0;
        wait_valid("t8_wait", 20);
        chk("t8_first_pc", pcOUT, 32'h0000_8000);
        repeat (4) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
